// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (CPU read/write, video read-only) memory arbiter; optional MEM_ARB_ROUND_ROBIN_EN
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    // IDLE picks a winner, ACCESS presents the request, RESP collects data and acks.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Grantee (1 = video) and direction of the access in flight.
    logic        grant_vid;
    logic        grant_vid_next;
    logic        access_we;
    logic        access_we_next;

    logic [15:0] mem_addr_next;
    logic        mem_we_next;
    logic [15:0] mem_wdata_next;
    logic        cpu_ack_next;
    logic        vid_ack_next;
    logic [15:0] cpu_rdata_next;
    logic [15:0] vid_rdata_next;

    // A requester whose ack is high this cycle has just been served and sits out one arbitration.
    logic        cpu_elig;
    logic        vid_elig;
    logic        pick_vid;

    assign cpu_elig = cpu_req & ~cpu_ack;
    assign vid_elig = vid_req & ~vid_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_vid = 1 means video was granted most recently; on a tie the other side wins.
    logic        last_vid;
    logic        last_vid_next;

    assign pick_vid = vid_elig & (~cpu_elig | ~last_vid);
`else
    // Fixed priority: video only wins when the CPU is not eligible.
    assign pick_vid = vid_elig & ~cpu_elig;
`endif

    assign busy = (state != IDLE);

    // Next-state and next-output decode; memory strobes default to 0 outside the ACCESS cycle.
    always_comb begin
        state_next     = state;
        grant_vid_next = grant_vid;
        access_we_next = access_we;
        mem_addr_next  = 16'h0000;
        mem_we_next    = 1'b0;
        mem_wdata_next = 16'h0000;
        cpu_ack_next   = 1'b0;
        vid_ack_next   = 1'b0;
        cpu_rdata_next = cpu_rdata;
        vid_rdata_next = vid_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_vid_next  = last_vid;
`endif
        case (state)
            IDLE: begin
                if (cpu_elig || vid_elig) begin
                    state_next     = ACCESS;
                    grant_vid_next = pick_vid;
                    access_we_next = cpu_we & ~pick_vid;
                    mem_addr_next  = pick_vid ? vid_addr : cpu_addr;
                    mem_we_next    = cpu_we & ~pick_vid;
                    mem_wdata_next = cpu_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_vid_next  = pick_vid;
`endif
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                if (grant_vid) begin
                    vid_ack_next   = 1'b1;
                    vid_rdata_next = mem_rdata;
                end else begin
                    cpu_ack_next = 1'b1;
                    if (!access_we) begin
                        cpu_rdata_next = mem_rdata;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_vid <= 1'b0;
            access_we <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_we    <= 1'b0;
            mem_wdata <= 16'h0000;
            cpu_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_rdata <= 16'h0000;
            vid_rdata <= 16'h0000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_vid  <= 1'b1;
`endif
        end else begin
            state     <= state_next;
            grant_vid <= grant_vid_next;
            access_we <= access_we_next;
            mem_addr  <= mem_addr_next;
            mem_we    <= mem_we_next;
            mem_wdata <= mem_wdata_next;
            cpu_ack   <= cpu_ack_next;
            vid_ack   <= vid_ack_next;
            cpu_rdata <= cpu_rdata_next;
            vid_rdata <= vid_rdata_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_vid  <= last_vid_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_ack   (vid_ack),
        .vid_rdata (vid_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a) ^ 16'h5A3C;
    endfunction

    // Synchronous-read memory attached to the arbiter.
    logic [15:0] mem [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0100] = 16'h00FF;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference memory contents seen by the random phase.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        vid_req   = 1'b0;
        vid_addr  = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Random-phase model state: cycle numbers of the pending acks and of the last grant.
    int          c;
    int          cpu_ack_at;
    int          vid_ack_at;
    int          free_at;
    int          g_c;
    logic        g_we;
    logic [15:0] g_addr;
    logic [15:0] g_wdata;
    logic        cpu_gr_we;
    logic [15:0] cpu_exp;
    logic [15:0] vid_exp;
    logic [15:0] m_cpu_rd;
    logic [15:0] m_vid_rd;
    logic        m_last_vid;
    logic        exp_ca;
    logic        exp_va;
    logic        ce;
    logic        ve;
    logic        win_vid;

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset state
        @(negedge clk);
        check1("rst_cpu_ack", cpu_ack, 1'b0);
        check1("rst_vid_ack", vid_ack, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check16("rst_cpu_rdata", cpu_rdata, 16'h0000);
        check16("rst_vid_rdata", vid_rdata, 16'h0000);
        check16("rst_mem_addr", mem_addr, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // CPU read 0x0010 -> 0xBEEF, ack at N+3
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        check16("rd_n1_mem_addr", mem_addr, 16'h0010);
        check1("rd_n1_mem_we", mem_we, 1'b0);
        check1("rd_n1_busy", busy, 1'b1);
        check1("rd_n1_cpu_ack", cpu_ack, 1'b0);
        @(negedge clk);
        check1("rd_n2_cpu_ack", cpu_ack, 1'b0);
        check16("rd_n2_mem_addr", mem_addr, 16'h0000);
        @(negedge clk);
        check1("rd_n3_cpu_ack", cpu_ack, 1'b1);
        check16("rd_n3_cpu_rdata", cpu_rdata, 16'hBEEF);
        check1("rd_n3_vid_ack", vid_ack, 1'b0);
        check1("rd_n3_busy", busy, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        check1("rd_n4_cpu_ack", cpu_ack, 1'b0);
        check16("rd_n4_cpu_rdata", cpu_rdata, 16'hBEEF);

        // CPU write 0x0020/0x1234
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        @(negedge clk);
        check1("wr_n1_mem_we", mem_we, 1'b1);
        check16("wr_n1_mem_addr", mem_addr, 16'h0020);
        check16("wr_n1_mem_wdata", mem_wdata, 16'h1234);
        @(negedge clk);
        check1("wr_n2_mem_we", mem_we, 1'b0);
        check16("wr_n2_mem_addr", mem_addr, 16'h0000);
        check16("wr_n2_mem_wdata", mem_wdata, 16'h0000);
        check1("wr_n2_cpu_ack", cpu_ack, 1'b0);
        @(negedge clk);
        check1("wr_n3_cpu_ack", cpu_ack, 1'b1);
        check16("wr_n3_cpu_rdata", cpu_rdata, 16'hBEEF);
        check1("wr_n3_mem_we", mem_we, 1'b0);
        idle_inputs();
        @(negedge clk);

`ifndef MEM_ARB_ROUND_ROBIN_EN
        // Fixed priority: both raised together, each held until its own ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        vid_req = 1'b1; vid_addr = 16'h0005;
        @(negedge clk);
        @(negedge clk);
        check1("pri_n2_cpu_ack", cpu_ack, 1'b0);
        @(negedge clk);
        check1("pri_n3_cpu_ack", cpu_ack, 1'b1);
        check1("pri_n3_vid_ack", vid_ack, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        check1("pri_n4_vid_ack", vid_ack, 1'b0);
        @(negedge clk);
        check1("pri_n5_vid_ack", vid_ack, 1'b0);
        @(negedge clk);
        check1("pri_n6_vid_ack", vid_ack, 1'b1);
        check1("pri_n6_cpu_ack", cpu_ack, 1'b0);
        check16("pri_n6_vid_rdata", vid_rdata, init_val(5));
        idle_inputs();
        @(negedge clk);
`endif

        // Video read 0x0100 -> 0x00FF with the CPU idle
        vid_req = 1'b1; vid_addr = 16'h0100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check1("vid_mem_we", mem_we, 1'b0);
            check1("vid_ack_step", vid_ack, k == 3);
            check1("vid_cpu_ack", cpu_ack, 1'b0);
        end
        check16("vid_n3_rdata", vid_rdata, 16'h00FF);
        check16("vid_n3_cpu_rdata", cpu_rdata, 16'hBEEF);
        vid_req = 1'b0;
        @(negedge clk);

        // A request dropped after sampling still completes
        vid_req = 1'b1; vid_addr = 16'h0010;
        @(negedge clk);
        vid_req = 1'b0;
        @(negedge clk);
        check1("drop_n2_vid_ack", vid_ack, 1'b0);
        @(negedge clk);
        check1("drop_n3_vid_ack", vid_ack, 1'b1);
        check16("drop_n3_vid_rdata", vid_rdata, 16'hBEEF);
        @(negedge clk);

        // Reset during ACCESS of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'hAAAA;
        @(negedge clk);
        check1("rstw_access_mem_we", mem_we, 1'b1);
        #1 reset = 1'b1;
        #1;
        check1("rstw_async_mem_we", mem_we, 1'b0);
        check1("rstw_async_busy", busy, 1'b0);
        check16("rstw_async_mem_addr", mem_addr, 16'h0000);
        check16("rstw_async_cpu_rdata", cpu_rdata, 16'h0000);
        idle_inputs();
        @(negedge clk);
        check1("rstw_hold_cpu_ack", cpu_ack, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        reset = 1'b0;
        @(negedge clk);
        check1("rstw_n1_cpu_ack", cpu_ack, 1'b0);
        check1("rstw_n1_busy", busy, 1'b1);
        @(negedge clk);
        check1("rstw_n2_cpu_ack", cpu_ack, 1'b0);
        @(negedge clk);
        check1("rstw_n3_cpu_ack", cpu_ack, 1'b1);
        check16("rstw_n3_cpu_rdata", cpu_rdata, 16'hBEEF);
        idle_inputs();
        @(negedge clk);

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Round robin: both requesting continuously, CPU first then strict alternation
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        vid_req = 1'b1; vid_addr = 16'h0002;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check1("rr_cpu_ack", cpu_ack, (k % 6) == 3);
            check1("rr_vid_ack", vid_ack, (k % 6) == 0);
        end
        idle_inputs();
        @(negedge clk);
`endif

        // Randomized traffic against a cycle-scheduled transaction model
        do_reset();
        cpu_ack_at = -100; vid_ack_at = -100; free_at = 0; g_c = -100;
        g_we = 1'b0; g_addr = 16'h0000; g_wdata = 16'h0000; cpu_gr_we = 1'b0;
        cpu_exp = 16'h0000; vid_exp = 16'h0000;
        m_cpu_rd = 16'h0000; m_vid_rd = 16'h0000; m_last_vid = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
        for (c = 0; c < 600; c++) begin
            exp_ca = (cpu_ack_at == c);
            exp_va = (vid_ack_at == c);
            if (exp_ca && !cpu_gr_we) m_cpu_rd = cpu_exp;
            if (exp_va) m_vid_rd = vid_exp;
            check1("rnd_cpu_ack", cpu_ack, exp_ca);
            check1("rnd_vid_ack", vid_ack, exp_va);
            check16("rnd_cpu_rdata", cpu_rdata, m_cpu_rd);
            check16("rnd_vid_rdata", vid_rdata, m_vid_rd);
            check1("rnd_busy", busy, (c > g_c) && (c < free_at));
            check1("rnd_mem_we", mem_we, g_we && (c == g_c + 1));
            check16("rnd_mem_addr", mem_addr, (c == g_c + 1) ? g_addr : 16'h0000);

            if (exp_ca) cpu_req = 1'b0;
            if (exp_va) vid_req = 1'b0;
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 7));
                cpu_wdata = 16'($urandom);
            end
            if (!vid_req && $urandom_range(0, 2) == 0) begin
                vid_req  = 1'b1;
                vid_addr = 16'($urandom_range(0, 7));
            end

            if (c >= free_at) begin
                ce = cpu_req && !exp_ca;
                ve = vid_req && !exp_va;
                if (ce || ve) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    win_vid = ve && (!ce || !m_last_vid);
`else
                    win_vid = ve && !ce;
`endif
                    m_last_vid = win_vid;
                    g_c = c;
                    free_at = c + 3;
                    if (win_vid) begin
                        g_we = 1'b0;
                        g_addr = vid_addr;
                        vid_exp = ref_rd(int'(vid_addr));
                        vid_ack_at = c + 3;
                    end else begin
                        g_we = cpu_we;
                        g_addr = cpu_addr;
                        g_wdata = cpu_wdata;
                        cpu_gr_we = cpu_we;
                        if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
                        else cpu_exp = ref_rd(int'(cpu_addr));
                        cpu_ack_at = c + 3;
                    end
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Ports SHALL be exactly as follows; name  direction  width  meaning (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0); valid while cpu_req
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  16  CPU read data, valid with cpu_ack
- vid_req  in  1  video read request (read-only port); held until vid_ack
- vid_addr  in  16  video word address
- vid_ack  out  1  one-cycle completion pulse to video
- vid_rdata  out  16  video read data, valid with vid_ack
- mem_addr  out  16  memory address, registered
- mem_we  out  1  memory write strobe, registered
- mem_wdata  out  16  memory write data, registered
- mem_rdata  in  16  memory read data; synchronous read, valid the cycle after mem_addr is presented
- busy  out  1  high whenever state is not IDLE

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-003 IDLE: if an eligible request exists, register the winner's address, cpu_we (forced 0 for video) and cpu_wdata onto mem_addr/mem_we/mem_wdata, record the grantee, go to ACCESS; else stay in IDLE.
REQ-004 ACCESS: hold the mem_* outputs for exactly one cycle, then go to RESP; mem_we SHALL be high only in ACCESS.
REQ-005 RESP: on a read, capture mem_rdata into the grantee's rdata register; pulse the grantee's ack high for exactly the next cycle; return to IDLE.
REQ-006 Latency: a request sampled in IDLE at cycle N SHALL produce ack at cycle N+3, for both reads and writes.
REQ-007 A write SHALL leave cpu_rdata unchanged.
REQ-008 The non-grantee's rdata and ack SHALL remain unchanged and low respectively.
REQ-009 In the cycle its ack is high, a requester SHALL NOT be eligible in IDLE; back-to-back requests from one requester therefore start no sooner than N+4.
REQ-010 Arbitration (default, macro absent): fixed priority; CPU wins when both are eligible.
REQ-011 mem_addr, mem_we and mem_wdata SHALL return to 0 in RESP and IDLE.
REQ-012 Requests that drop before ack SHALL NOT abort an access in progress; the access completes and acks normally.
REQ-013 Address and data SHALL pass through unmodified at 16 bits; there is no address translation.

Reset
REQ-014 Asserting reset SHALL immediately force state to IDLE and all outputs to 0, including mem_we, cpu_rdata and vid_rdata.
REQ-015 Reset in any state SHALL abort the current access with no ack, and the round-robin pointer SHALL reset to "video last granted".
REQ-016 The first edge after reset deassertion SHALL evaluate requests in IDLE.

Configuration
REQ-017 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, a 1-bit last-grant register SHALL be maintained, and on simultaneous eligible requests the requester not last granted SHALL win. When undefined, the register SHALL be absent and REQ-010 fixed priority SHALL apply.

Verification
REQ-018 The bench SHALL cover these scenarios:
- CPU read 0x0010 at N, memory returns 0xBEEF: cpu_ack=1 and cpu_rdata=0xBEEF at N+3 only; vid_ack stays 0.
- CPU write 0x0020/0x1234 at N: mem_we=1, mem_addr=0x0020, mem_wdata=0x1234 at N+1 only; cpu_ack at N+3; cpu_rdata unchanged.
- Fixed priority, cpu_req and vid_req both raised at N and held until ack: cpu_ack at N+3, vid_ack at N+6.
- MEM_ARB_ROUND_ROBIN_EN, both requesters re-requesting continuously: first grant CPU, then grants strictly alternate CPU/video every 3 cycles.
- Reset asserted during ACCESS of a CPU write: mem_we drops to 0 asynchronously; no cpu_ack issued; busy=0; next request acked 3 cycles after sampling.
- Video read 0x0100 returning 0x00FF while CPU idle: vid_rdata=0x00FF with vid_ack at N+3; mem_we never asserted.
